writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- MEM/WB pipeline register plus write-back logic for the MIPS pipeline.
- Captures the memory-stage result, aligns and extends load data, and drives the write port of the general purpose register file one cycle later.
- Also exports a forwarding copy of the pending write for the hazard unit, a retired-instruction counter, and a sticky misaligned-load flag.

Parameters:
- DATA_WIDTH, 32, datapath width; only 32 is supported.
- ADDRESS_SIZE, 5, register address width.
- COUNTER_WIDTH, 32, width of retired_count.

Ports:
- system_clock  input  1  pipeline clock; all state updates on the rising edge.
- system_reset_n  input  1  asynchronous, active-low reset.
- flush  input  1  squashes the instruction being captured this cycle.
- mem_valid  input  1  the MEM stage holds a real instruction.
- mem_reg_write  input  1  the instruction writes a register.
- mem_mem_to_reg  input  1  1 = load data, 0 = ALU result.
- mem_dest_address  input  ADDRESS_SIZE  destination register.
- mem_alu_result  input  DATA_WIDTH  ALU result; bits [1:0] are the load byte offset.
- mem_load_data  input  DATA_WIDTH  raw word read from data memory.
- mem_load_size  input  2  00 word, 01 halfword, 10 byte, 11 reserved (treated as word).
- mem_load_unsigned  input  1  1 = zero-extend, 0 = sign-extend.
- clear_exception  input  1  clears misaligned_load.
- rf_write_enable  output  1  register file write enable.
- rf_write_address  output  ADDRESS_SIZE  register file write address.
- rf_write_data  output  DATA_WIDTH  register file write data.
- forward_valid  output  1  a write is pending in WB; equals rf_write_enable.
- forward_address  output  ADDRESS_SIZE  same as rf_write_address.
- forward_data  output  DATA_WIDTH  same as rf_write_data.
- retired_count  output  COUNTER_WIDTH  number of instructions retired.
- misaligned_load  output  1  sticky flag: a misaligned load was dropped.

Behaviour:
- Reset (async assert, release synchronous to the clock): the WB register is cleared (valid=0, dest=0, data=0). All outputs read 0 while reset is held and after release; retired_count=0, misaligned_load=0.
- Capture: every rising edge loads wb_valid <= mem_valid & ~flush, together with dest, reg_write and the selected data. No stall input; MEM sequencing is the upstream block's responsibility.
- Data select at capture:
  - mem_to_reg=0: the ALU result.
  - mem_to_reg=1, word: mem_load_data as-is.
  - halfword: offset 0 selects bits [15:0], offset 2 selects bits [31:16] (little-endian lanes).
  - byte: offset n selects bits [8n+7:8n].
  - Extension to 32 bits per mem_load_unsigned.
- Misaligned: a halfword load with offset bit0=1, or a word load with offset≠0. The instruction is captured with reg_write forced to 0 and counts as retired. misaligned_load sets on the cycle after capture and holds until clear_exception; a set and a clear in the same cycle resolves to set.
- Outputs are registered only:
  - rf_write_enable = wb_valid & wb_reg_write & (wb_dest≠0).
  - address and data are driven from the WB register even when the enable is 0.
- Latency: MEM inputs to register-file write is exactly 1 cycle. The register file stores the value on the following edge. Consumers in the same cycle see it via forward_*.
- Back-to-back instructions are fully pipelined; one retires per cycle.
- retired_count increments by 1 on each edge where wb_valid=1, including non-writing and misaligned instructions. It wraps modulo 2^COUNTER_WIDTH with no saturation.
- flush with mem_valid=1: the bubble is captured, nothing is written, and the count is not incremented.
- Reset mid-stream: a pending write is discarded immediately and rf_write_enable drops asynchronously.

Test Plan:
- ALU op: mem_valid=1, reg_write=1, dest=5, alu_result=0x1234_5678, mem_to_reg=0 -> next cycle rf_write_enable=1, addr=5, data=0x12345678, forward_* identical, retired_count=1.
- Signed byte load: data=0x80FF_7F01, offset=3, size=byte, unsigned=0 -> rf_write_data=0xFFFF_FF80; same case with unsigned=1 -> 0x0000_0080; offset=2 with unsigned=0 -> 0xFFFF_FFFF.
- Halfword/misaligned: offset=2 halfword signed on 0x8001_0000 -> 0xFFFF_8001. Offset=1 halfword -> rf_write_enable=0, misaligned_load=1 and held until clear_exception, retired_count still increments.
- $0 and flush: dest=0 reg_write=1 -> rf_write_enable=0, count+1. flush=1 with valid instruction -> rf_write_enable=0, count unchanged.
- Counter wrap: COUNTER_WIDTH=4, 17 valid instructions back-to-back -> retired_count=1; 4 instructions with 2 bubbles interleaved -> count+4.
- Async reset: assert system_reset_n=0 mid-cycle while rf_write_enable=1 -> enable drops before the next edge, all outputs 0; after release the first captured instruction writes correctly.

Source files
------------

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with load alignment/extension driving the GPR write port and hazard forwarding.
// Latency: MEM inputs appear on rf_write_* / forward_* exactly one cycle later; fully pipelined, one retire per cycle.
// Backpressure: none; captures every cycle, and MEM sequencing and squashing are handled upstream via flush.
module writeback_stage #(
  parameter int DATA_WIDTH    = 32,  // only 32 is supported (lane selects assume a 4-byte word)
  parameter int ADDRESS_SIZE  = 5,
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                     system_clock,
  input  logic                     system_reset_n,
  input  logic                     flush,
  input  logic                     mem_valid,
  input  logic                     mem_reg_write,
  input  logic                     mem_mem_to_reg,
  input  logic [ADDRESS_SIZE-1:0]  mem_dest_address,
  input  logic [DATA_WIDTH-1:0]    mem_alu_result,
  input  logic [DATA_WIDTH-1:0]    mem_load_data,
  input  logic [1:0]               mem_load_size,
  input  logic                     mem_load_unsigned,
  input  logic                     clear_exception,
  output logic                     rf_write_enable,
  output logic [ADDRESS_SIZE-1:0]  rf_write_address,
  output logic [DATA_WIDTH-1:0]    rf_write_data,
  output logic                     forward_valid,
  output logic [ADDRESS_SIZE-1:0]  forward_address,
  output logic [DATA_WIDTH-1:0]    forward_data,
  output logic [COUNTER_WIDTH-1:0] retired_count,
  output logic                     misaligned_load
);

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  logic                     w_capture;
  logic [1:0]               w_offset;
  logic                     w_misaligned;
  logic                     w_write_next;
  logic [15:0]              w_half;
  logic [7:0]               w_byte;
  logic [DATA_WIDTH-1:0]    w_load_value;
  logic [DATA_WIDTH-1:0]    w_data_next;

  logic                     r_write_enable;
  logic [ADDRESS_SIZE-1:0]  r_dest;
  logic [DATA_WIDTH-1:0]    r_data;
  logic [COUNTER_WIDTH-1:0] r_retired;
  logic                     r_misaligned;

  // A flushed slot becomes a bubble: it neither writes nor retires.
  assign w_capture = mem_valid & ~flush;
  assign w_offset  = mem_alu_result[1:0];

  // Halfwords must be 2-byte aligned; words (and the reserved size, treated as word) 4-byte aligned.
  assign w_misaligned = w_capture & mem_mem_to_reg &
                        (((mem_load_size == SIZE_HALF) & w_offset[0]) |
                         (((mem_load_size == SIZE_WORD) | (mem_load_size == 2'b11)) & (w_offset != 2'b00)));

  // $0 is hardwired to zero, so writes to it are suppressed here rather than in the register file.
  assign w_write_next = w_capture & mem_reg_write & ~w_misaligned &
                        (mem_dest_address != '0);

  // Little-endian lane selection; odd halfword offsets only reach here when the load is being dropped.
  assign w_half = w_offset[1] ? mem_load_data[31:16] : mem_load_data[15:0];

  // Byte lane select by offset.
  always_comb begin
    w_byte = mem_load_data[7:0];
    case (w_offset)
      2'd0:    w_byte = mem_load_data[7:0];
      2'd1:    w_byte = mem_load_data[15:8];
      2'd2:    w_byte = mem_load_data[23:16];
      default: w_byte = mem_load_data[31:24];
    endcase
  end

  // Size-dependent zero/sign extension of the selected lane.
  always_comb begin
    w_load_value = mem_load_data;
    case (mem_load_size)
      SIZE_HALF: w_load_value = {{(DATA_WIDTH-16){~mem_load_unsigned & w_half[15]}}, w_half};
      SIZE_BYTE: w_load_value = {{(DATA_WIDTH-8){~mem_load_unsigned & w_byte[7]}}, w_byte};
      default:   w_load_value = mem_load_data;
    endcase
  end

  assign w_data_next = mem_mem_to_reg ? w_load_value : mem_alu_result;

  // WB pipeline register: address and data load every edge, enable carries the qualified write.
  always_ff @(posedge system_clock or negedge system_reset_n) begin
    if (!system_reset_n) begin
      r_write_enable <= 1'b0;
      r_dest         <= '0;
      r_data         <= '0;
    end else begin
      r_write_enable <= w_write_next;
      r_dest         <= mem_dest_address;
      r_data         <= w_data_next;
    end
  end

  // Retire counter advances as each real instruction enters WB, so it is current alongside the write; wraps freely.
  always_ff @(posedge system_clock or negedge system_reset_n) begin
    if (!system_reset_n) begin
      r_retired <= '0;
    end else if (w_capture) begin
      r_retired <= r_retired + {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Sticky misaligned flag; a new event beats a simultaneous clear so no drop goes unreported.
  always_ff @(posedge system_clock or negedge system_reset_n) begin
    if (!system_reset_n) begin
      r_misaligned <= 1'b0;
    end else begin
      r_misaligned <= w_misaligned | (r_misaligned & ~clear_exception);
    end
  end

  assign rf_write_enable  = r_write_enable;
  assign rf_write_address = r_dest;
  assign rf_write_data    = r_data;
  assign forward_valid    = r_write_enable;
  assign forward_address  = r_dest;
  assign forward_data     = r_data;
  assign retired_count    = r_retired;
  assign misaligned_load  = r_misaligned;

endmodule

// File: tb/tb_writeback_stage.sv
// Testbench for writeback_stage: directed cases plus randomized traffic against a behavioural model.
// Latency: checks each captured instruction one cycle later, sampled on the falling edge.
// Backpressure: none exercised; the DUT has no stall path.
module tb_writeback_stage;

  logic        system_clock = 1'b0;
  logic        system_reset_n;
  logic        flush, mem_valid, mem_reg_write, mem_mem_to_reg;
  logic [4:0]  mem_dest_address;
  logic [31:0] mem_alu_result, mem_load_data;
  logic [1:0]  mem_load_size;
  logic        mem_load_unsigned, clear_exception;

  logic        rf_write_enable, forward_valid, misaligned_load;
  logic [4:0]  rf_write_address, forward_address;
  logic [31:0] rf_write_data, forward_data, retired_count;

  logic        b_rf_write_enable, b_forward_valid, b_misaligned_load;
  logic [4:0]  b_rf_write_address, b_forward_address;
  logic [31:0] b_rf_write_data, b_forward_data;
  logic [3:0]  b_retired_count;

  int errors = 0;
  int checks = 0;

  logic        exp_wen;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  logic        exp_data_known;
  logic [31:0] exp_cnt;
  logic        exp_mis;

  always #5 system_clock = ~system_clock;

  writeback_stage dut (
    .system_clock(system_clock), .system_reset_n(system_reset_n), .flush(flush),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg),
    .mem_dest_address(mem_dest_address), .mem_alu_result(mem_alu_result),
    .mem_load_data(mem_load_data), .mem_load_size(mem_load_size),
    .mem_load_unsigned(mem_load_unsigned), .clear_exception(clear_exception),
    .rf_write_enable(rf_write_enable), .rf_write_address(rf_write_address),
    .rf_write_data(rf_write_data), .forward_valid(forward_valid),
    .forward_address(forward_address), .forward_data(forward_data),
    .retired_count(retired_count), .misaligned_load(misaligned_load)
  );

  writeback_stage #(.COUNTER_WIDTH(4)) dut4 (
    .system_clock(system_clock), .system_reset_n(system_reset_n), .flush(flush),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg),
    .mem_dest_address(mem_dest_address), .mem_alu_result(mem_alu_result),
    .mem_load_data(mem_load_data), .mem_load_size(mem_load_size),
    .mem_load_unsigned(mem_load_unsigned), .clear_exception(clear_exception),
    .rf_write_enable(b_rf_write_enable), .rf_write_address(b_rf_write_address),
    .rf_write_data(b_rf_write_data), .forward_valid(b_forward_valid),
    .forward_address(b_forward_address), .forward_data(b_forward_data),
    .retired_count(b_retired_count), .misaligned_load(b_misaligned_load)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference load result: shift the addressed lane down, mask, then extend arithmetically.
  function automatic logic [31:0] ref_load(input logic [31:0] word, input int off,
                                           input logic [1:0] size, input logic uns);
    logic [31:0] v;
    if (size == 2'b01) begin
      v = (word >> (16 * (off / 2))) & 32'h0000_FFFF;
      if (!uns && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end else if (size == 2'b10) begin
      v = (word >> (8 * off)) & 32'h0000_00FF;
      if (!uns && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end else begin
      v = word;
    end
    return v;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".wen"},  {63'd0, rf_write_enable}, {63'd0, exp_wen});
    check({tag, ".addr"}, {59'd0, rf_write_address}, {59'd0, exp_addr});
    if (exp_data_known) check({tag, ".data"}, {32'd0, rf_write_data}, {32'd0, exp_data});
    check({tag, ".fwd"},  {forward_valid, forward_address, forward_data},
                          {rf_write_enable, rf_write_address, rf_write_data});
    check({tag, ".cnt"},  {32'd0, retired_count}, {32'd0, exp_cnt});
    check({tag, ".cnt4"}, {60'd0, b_retired_count}, {60'd0, exp_cnt[3:0]});
    check({tag, ".mis"},  {63'd0, misaligned_load}, {63'd0, exp_mis});
    check({tag, ".dut4"}, {b_rf_write_enable, b_rf_write_address, b_rf_write_data,
                           b_forward_valid, b_forward_address, b_misaligned_load},
                          {rf_write_enable, rf_write_address, rf_write_data,
                           forward_valid, forward_address, misaligned_load});
    check({tag, ".fd4"},  {32'd0, b_forward_data}, {32'd0, rf_write_data});
  endtask

  // One instruction through the stage: drive at the falling edge, update the model, check after the edge.
  task automatic step(input string tag, input logic v, input logic fl, input logic rw,
                      input logic m2r, input logic [4:0] dest, input logic [31:0] alu,
                      input logic [31:0] ld, input logic [1:0] sz, input logic uns,
                      input logic clr);
    int  off;
    bit  live, mis;
    mem_valid = v; flush = fl; mem_reg_write = rw; mem_mem_to_reg = m2r;
    mem_dest_address = dest; mem_alu_result = alu; mem_load_data = ld;
    mem_load_size = sz; mem_load_unsigned = uns; clear_exception = clr;
    off  = int'(alu % 4);
    live = v && !fl;
    mis  = live && m2r && ((sz == 2'b01 && (off % 2) == 1) ||
                           ((sz == 2'b00 || sz == 2'b11) && off != 0));
    exp_wen        = live && rw && !mis && dest != 0;
    exp_addr       = dest;
    exp_data       = m2r ? ref_load(ld, off, sz, uns) : alu;
    exp_data_known = !mis;
    if (live) exp_cnt = exp_cnt + 1;
    exp_mis = mis ? 1'b1 : (clr ? 1'b0 : exp_mis);
    @(posedge system_clock);
    @(negedge system_clock);
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input logic clr);
    step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 2'b00, 1'b0, clr);
  endtask

  initial begin
    logic [31:0] c0;
    system_reset_n = 1'b0;
    flush = 0; mem_valid = 0; mem_reg_write = 0; mem_mem_to_reg = 0;
    mem_dest_address = 0; mem_alu_result = 0; mem_load_data = 0;
    mem_load_size = 0; mem_load_unsigned = 0; clear_exception = 0;
    exp_wen = 0; exp_addr = 0; exp_data = 0; exp_data_known = 1; exp_cnt = 0; exp_mis = 0;

    #12;
    check_outputs("reset_held");
    check("reset_data", {32'd0, rf_write_data}, 64'd0);
    @(negedge system_clock);
    system_reset_n = 1'b1;
    idle("reset_release", 1'b0);

    // ALU result write
    step("alu", 1, 0, 1, 0, 5'd5, 32'h1234_5678, 32'd0, 2'b00, 0, 0);
    check("alu_const", {rf_write_enable, rf_write_address, rf_write_data, retired_count},
                       {1'b1, 5'd5, 32'h1234_5678, 32'd1});

    // Byte loads
    step("byte_s3", 1, 0, 1, 1, 5'd7, 32'h0000_0003, 32'h80FF_7F01, 2'b10, 0, 0);
    check("byte_s3_const", {32'd0, rf_write_data}, {32'd0, 32'hFFFF_FF80});
    step("byte_u3", 1, 0, 1, 1, 5'd7, 32'h0000_0003, 32'h80FF_7F01, 2'b10, 1, 0);
    check("byte_u3_const", {32'd0, rf_write_data}, {32'd0, 32'h0000_0080});
    step("byte_s2", 1, 0, 1, 1, 5'd8, 32'h0000_0002, 32'h80FF_7F01, 2'b10, 0, 0);
    check("byte_s2_const", {32'd0, rf_write_data}, {32'd0, 32'hFFFF_FFFF});

    // Halfword and misaligned handling
    step("half_s2", 1, 0, 1, 1, 5'd9, 32'h0000_0002, 32'h8001_0000, 2'b01, 0, 0);
    check("half_s2_const", {32'd0, rf_write_data}, {32'd0, 32'hFFFF_8001});
    c0 = exp_cnt;
    step("half_mis", 1, 0, 1, 1, 5'd9, 32'h0000_0001, 32'h8001_0000, 2'b01, 0, 0);
    check("half_mis_const", {misaligned_load, rf_write_enable, retired_count}, {1'b1, 1'b0, c0 + 32'd1});
    idle("mis_hold", 0);
    check("mis_hold_const", {63'd0, misaligned_load}, 64'd1);
    step("mis_setclr", 1, 0, 1, 1, 5'd3, 32'h0000_0002, 32'h1, 2'b00, 0, 1);
    idle("mis_clear", 1);
    check("mis_clear_const", {63'd0, misaligned_load}, 64'd0);

    // $0 destination and flush
    c0 = exp_cnt;
    step("dest0", 1, 0, 1, 0, 5'd0, 32'hDEAD_BEEF, 32'd0, 2'b00, 0, 0);
    check("dest0_const", {rf_write_enable, retired_count}, {1'b0, c0 + 32'd1});
    step("flush", 1, 1, 1, 0, 5'd4, 32'hCAFE_F00D, 32'd0, 2'b00, 0, 0);
    check("flush_const", {rf_write_enable, retired_count}, {1'b0, c0 + 32'd1});

    // Counter wrap on the 4-bit instance: 17 back-to-back, then 4 instructions with 2 bubbles
    c0 = exp_cnt;
    for (int i = 0; i < 17; i++)
      step("b2b", 1, 0, 1, 0, 5'(i + 1), 32'(i * 3 + 1), 32'd0, 2'b00, 0, 0);
    check("wrap17", {60'd0, b_retired_count}, {60'd0, 4'(c0 + 32'd1)});
    c0 = exp_cnt;
    step("gap_a", 1, 0, 1, 0, 5'd10, 32'd100, 32'd0, 2'b00, 0, 0);
    idle("gap_b0", 0);
    step("gap_c", 1, 0, 1, 0, 5'd11, 32'd101, 32'd0, 2'b00, 0, 0);
    step("gap_d", 1, 0, 1, 0, 5'd12, 32'd102, 32'd0, 2'b00, 0, 0);
    idle("gap_b1", 0);
    step("gap_f", 1, 0, 1, 0, 5'd13, 32'd103, 32'd0, 2'b00, 0, 0);
    check("gap_cnt", {32'd0, retired_count}, {32'd0, c0 + 32'd4});

    // Asynchronous reset while a write is pending
    step("pre_rst", 1, 1, 0, 0, 5'd0, 32'd0, 32'd0, 2'b00, 0, 0);
    step("pre_rst_w", 0, 0, 1, 0, 5'd14, 32'h5555_AAAA, 32'd0, 2'b00, 0, 0);
    step("pre_rst_w2", 1, 0, 1, 0, 5'd14, 32'h5555_AAAA, 32'd0, 2'b00, 0, 0);
    mem_valid = 1'b0;
    #2 system_reset_n = 1'b0;
    #1;
    exp_wen = 0; exp_addr = 0; exp_data = 0; exp_data_known = 1; exp_cnt = 0; exp_mis = 0;
    check_outputs("async_rst");
    check("async_rst_all", {rf_write_enable, rf_write_address, rf_write_data, retired_count},
                           64'd0);
    @(negedge system_clock);
    system_reset_n = 1'b1;
    step("post_rst", 1, 0, 1, 0, 5'd6, 32'h0BAD_CAFE, 32'd0, 2'b00, 0, 0);
    check("post_rst_const", {rf_write_enable, rf_write_address, rf_write_data, retired_count},
                            {1'b1, 5'd6, 32'h0BAD_CAFE, 32'd1});

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      step("rand",
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom),
           $urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
